// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: accumulates three coin denominations,
// sells one of NUM_ITEMS priced products and pays change back one coin per cycle.
module vending_machine_multi #(
   parameter int                     NUM_ITEMS  = 4,
   parameter int                     IDX_W      = 2,
   parameter int                     VAL_W      = 8,
   parameter logic [NUM_ITEMS*VAL_W-1:0] PRICES = 32'h64_3C_28_1E,
   parameter int                     COIN1      = 10,
   parameter int                     COIN2      = 20,
   parameter int                     COIN3      = 50,
   parameter int                     MAX_CREDIT = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       cash,
   input  logic [IDX_W-1:0] sel,
   input  logic             buy,
   input  logic             cancel,
   output logic             dispense,
   output logic [IDX_W-1:0] item_out,
   output logic [1:0]       retChange,
   output logic [VAL_W-1:0] credit,
   output logic             deny,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   localparam logic [VAL_W-1:0] C1    = VAL_W'(COIN1);
   localparam logic [VAL_W-1:0] C2    = VAL_W'(COIN2);
   localparam logic [VAL_W-1:0] C3    = VAL_W'(COIN3);
   localparam logic [VAL_W:0]   MAX_W = (VAL_W+1)'(MAX_CREDIT);

   state_t             state, state_nx;
   logic [VAL_W-1:0]   credit_nx;
   logic [IDX_W-1:0]   item_nx;
   logic [1:0]         ret_nx;
   logic               dispense_nx, deny_nx, busy_nx;

   logic [VAL_W-1:0]   price, coin_val, chg_rem;
   logic [VAL_W:0]     sum;
   logic [1:0]         chg_code;
   logic               sel_ok;

   // Price lookup bounded by NUM_ITEMS so an out-of-range sel never indexes PRICES.
   always_comb begin
      price  = '0;
      sel_ok = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (sel == IDX_W'(i)) begin
            price  = PRICES[i*VAL_W +: VAL_W];
            sel_ok = 1'b1;
         end
      end
   end

   always_comb begin
      unique case (cash)
         2'b01:   coin_val = C1;
         2'b10:   coin_val = C2;
         2'b11:   coin_val = C3;
         default: coin_val = '0;
      endcase
   end

   assign sum = {1'b0, credit} + {1'b0, coin_val};

   // Greedy change step; relies on COIN3 > COIN2 > COIN1.
   always_comb begin
      if (credit >= C3) begin
         chg_code = 2'b11;
         chg_rem  = credit - C3;
      end else if (credit >= C2) begin
         chg_code = 2'b10;
         chg_rem  = credit - C2;
      end else if (credit >= C1) begin
         chg_code = 2'b01;
         chg_rem  = credit - C1;
      end else begin
         chg_code = 2'b00;
         chg_rem  = '0;
      end
   end

   // NOTE: every output of this block gets a default first so no path leaves
   // a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx    = state;
      credit_nx   = credit;
      item_nx     = item_out;
      ret_nx      = 2'b00;
      dispense_nx = 1'b0;
      deny_nx     = 1'b0;
      unique case (state)
         IDLE, CREDIT: begin
            if (cancel) begin
               ret_nx = cash;
               if (credit != '0) begin
                  state_nx = CHANGE;
                  // A coin rejected this cycle owns retChange; change starts next cycle.
                  if (cash == 2'b00) begin
                     ret_nx    = chg_code;
                     credit_nx = chg_rem;
                  end
               end
            end else if (buy) begin
               ret_nx = cash;
               if (!sel_ok || credit < price) begin
                  deny_nx = 1'b1;
               end else begin
                  state_nx    = VEND;
                  dispense_nx = 1'b1;
                  item_nx     = sel;
                  credit_nx   = credit - price;
               end
            end else if (cash != 2'b00) begin
               if (sum <= MAX_W) begin
                  credit_nx = sum[VAL_W-1:0];
                  state_nx  = CREDIT;
               end else begin
                  ret_nx = cash;
               end
            end
         end
         VEND: begin
            if (credit != '0) begin
               state_nx  = CHANGE;
               ret_nx    = chg_code;
               credit_nx = chg_rem;
            end else begin
               state_nx = IDLE;
            end
         end
         CHANGE: begin
            if (credit < C1) begin
               // Covers both "paid out" and an unpayable remainder below COIN1.
               state_nx  = IDLE;
               credit_nx = '0;
            end else begin
               ret_nx    = chg_code;
               credit_nx = chg_rem;
            end
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx == VEND) || (state_nx == CHANGE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         credit    <= '0;
         item_out  <= '0;
         retChange <= 2'b00;
         dispense  <= 1'b0;
         deny      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nx;
         credit    <= credit_nx;
         item_out  <= item_nx;
         retChange <= ret_nx;
         dispense  <= dispense_nx;
         deny      <= deny_nx;
         busy      <= busy_nx;
      end
   end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed self-checking bench for vending_machine_multi with hand-computed
// expectations for the default price table and coin values.
module tb_vending_machine_multi;

   localparam int IDX_W = 2;
   localparam int VAL_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [1:0]       cash = 2'b00;
   logic [IDX_W-1:0] sel = '0;
   logic             buy = 1'b0;
   logic             cancel = 1'b0;
   logic             dispense;
   logic [IDX_W-1:0] item_out;
   logic [1:0]       retChange;
   logic [VAL_W-1:0] credit;
   logic             deny;
   logic             busy;

   int n_pass  = 0;
   int n_total = 0;

   vending_machine_multi dut (
      .clk       (clk),
      .rst       (rst),
      .cash      (cash),
      .sel       (sel),
      .buy       (buy),
      .cancel    (cancel),
      .dispense  (dispense),
      .item_out  (item_out),
      .retChange (retChange),
      .credit    (credit),
      .deny      (deny),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Drive one cycle of inputs, let the edge sample them, then return to idle
   // inputs; outputs are stable for checking until the next rising edge.
   task automatic tick(input logic [1:0] c, input logic [IDX_W-1:0] s,
                       input logic b, input logic k);
      cash   = c;
      sel    = s;
      buy    = b;
      cancel = k;
      @(posedge clk);
      #1;
      cash   = 2'b00;
      buy    = 1'b0;
      cancel = 1'b0;
   endtask

   task automatic idle_cycle();
      tick(2'b00, '0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_credit", 32'(credit), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ret", 32'(retChange), 0);
      check("rst_disp", 32'(dispense), 0);
      check("rst_deny", 32'(deny), 0);
      @(negedge clk);
      rst = 1'b1;

      // Three COIN1 then buy item 0 (price 30), exact credit
      tick(2'b01, '0, 1'b0, 1'b0);
      check("t1_credit10", 32'(credit), 10);
      tick(2'b01, '0, 1'b0, 1'b0);
      check("t1_credit20", 32'(credit), 20);
      tick(2'b01, '0, 1'b0, 1'b0);
      check("t1_credit30", 32'(credit), 30);
      tick(2'b00, 2'd0, 1'b1, 1'b0);
      check("t1_disp", 32'(dispense), 1);
      check("t1_item", 32'(item_out), 0);
      check("t1_credit0", 32'(credit), 0);
      check("t1_ret", 32'(retChange), 0);
      check("t1_busy", 32'(busy), 1);
      idle_cycle();
      check("t1_disp_off", 32'(dispense), 0);
      check("t1_ret_idle", 32'(retChange), 0);
      check("t1_busy_off", 32'(busy), 0);

      // COIN3 then buy item 1 (price 40): 10 change as one COIN1
      tick(2'b11, '0, 1'b0, 1'b0);
      check("t2_credit50", 32'(credit), 50);
      tick(2'b00, 2'd1, 1'b1, 1'b0);
      check("t2_disp", 32'(dispense), 1);
      check("t2_item", 32'(item_out), 1);
      check("t2_credit10", 32'(credit), 10);
      check("t2_busy_a", 32'(busy), 1);
      idle_cycle();
      check("t2_ret01", 32'(retChange), 1);
      check("t2_credit0", 32'(credit), 0);
      check("t2_busy_b", 32'(busy), 1);
      check("t2_disp_off", 32'(dispense), 0);
      idle_cycle();
      check("t2_ret00", 32'(retChange), 0);
      check("t2_busy_off", 32'(busy), 0);

      // 120 credit then cancel: change 50,50,20
      tick(2'b11, '0, 1'b0, 1'b0);
      tick(2'b11, '0, 1'b0, 1'b0);
      tick(2'b10, '0, 1'b0, 1'b0);
      check("t3_credit120", 32'(credit), 120);
      tick(2'b00, '0, 1'b0, 1'b1);
      check("t3_ret_a", 32'(retChange), 3);
      check("t3_credit70", 32'(credit), 70);
      check("t3_busy_a", 32'(busy), 1);
      idle_cycle();
      check("t3_ret_b", 32'(retChange), 3);
      check("t3_credit20", 32'(credit), 20);
      check("t3_busy_b", 32'(busy), 1);
      idle_cycle();
      check("t3_ret_c", 32'(retChange), 2);
      check("t3_credit0", 32'(credit), 0);
      check("t3_busy_c", 32'(busy), 1);
      check("t3_no_disp", 32'(dispense), 0);
      idle_cycle();
      check("t3_ret_end", 32'(retChange), 0);
      check("t3_busy_end", 32'(busy), 0);

      // Insufficient credit for items 2 and 3
      tick(2'b10, '0, 1'b0, 1'b0);
      check("t4_credit20", 32'(credit), 20);
      tick(2'b00, 2'd2, 1'b1, 1'b0);
      check("t4_deny2", 32'(deny), 1);
      check("t4_nodisp2", 32'(dispense), 0);
      check("t4_credit_kept", 32'(credit), 20);
      check("t4_busy", 32'(busy), 0);
      idle_cycle();
      check("t4_deny_pulse", 32'(deny), 0);
      tick(2'b00, 2'd3, 1'b1, 1'b0);
      check("t4_deny3", 32'(deny), 1);
      check("t4_credit_kept3", 32'(credit), 20);
      tick(2'b00, '0, 1'b0, 1'b1);
      check("t4_refund", 32'(retChange), 2);
      check("t4_refund_cr", 32'(credit), 0);
      idle_cycle();
      check("t4_idle_busy", 32'(busy), 0);

      // Coin together with buy is rejected, buy with zero credit denied
      tick(2'b10, 2'd0, 1'b1, 1'b0);
      check("t4b_deny", 32'(deny), 1);
      check("t4b_ret", 32'(retChange), 2);
      check("t4b_credit", 32'(credit), 0);
      // Cancel with zero credit has no effect
      tick(2'b00, '0, 1'b0, 1'b1);
      check("t4c_busy", 32'(busy), 0);
      check("t4c_ret", 32'(retChange), 0);

      // MAX_CREDIT boundary
      tick(2'b11, '0, 1'b0, 1'b0);
      tick(2'b11, '0, 1'b0, 1'b0);
      tick(2'b11, '0, 1'b0, 1'b0);
      tick(2'b10, '0, 1'b0, 1'b0);
      tick(2'b01, '0, 1'b0, 1'b0);
      check("t5_credit180", 32'(credit), 180);
      tick(2'b11, '0, 1'b0, 1'b0);
      check("t5_reject_ret", 32'(retChange), 3);
      check("t5_reject_cr", 32'(credit), 180);
      tick(2'b10, '0, 1'b0, 1'b0);
      check("t5_credit200", 32'(credit), 200);
      check("t5_ret_clear", 32'(retChange), 0);
      tick(2'b01, '0, 1'b0, 1'b0);
      check("t5_over_ret", 32'(retChange), 1);
      check("t5_over_cr", 32'(credit), 200);
      tick(2'b00, '0, 1'b0, 1'b1);
      check("t5_chg_first", 32'(retChange), 3);
      check("t5_chg_cr", 32'(credit), 150);
      repeat (4) idle_cycle();
      check("t5_drained", 32'(credit), 0);
      check("t5_drained_busy", 32'(busy), 0);

      // Asynchronous reset in the middle of CHANGE
      tick(2'b11, '0, 1'b0, 1'b0);
      tick(2'b11, '0, 1'b0, 1'b0);
      check("t6_credit100", 32'(credit), 100);
      tick(2'b00, 2'd1, 1'b1, 1'b0);
      check("t6_credit60", 32'(credit), 60);
      idle_cycle();
      check("t6_chg_ret", 32'(retChange), 3);
      check("t6_chg_cr", 32'(credit), 10);
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_cr", 32'(credit), 0);
      check("t6_async_ret", 32'(retChange), 0);
      check("t6_async_busy", 32'(busy), 0);
      check("t6_async_disp", 32'(dispense), 0);
      @(negedge clk);
      rst = 1'b1;
      idle_cycle();
      check("t6_post_cr", 32'(credit), 0);
      check("t6_post_busy", 32'(busy), 0);
      check("t6_post_ret", 32'(retChange), 0);
      tick(2'b01, '0, 1'b0, 1'b0);
      check("t6_post_coin", 32'(credit), 10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
